// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

  localparam int unsigned OP_MULT         = 0;
  localparam int unsigned OP_DIV          = 1;
  localparam int unsigned OP_UNSIGNED_BIT = 1;

  // Bits needed to hold values 0..v-1; called with WIDTH+1 to size the iteration counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module md_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// Optional MULTDIV_UNSIGNED_EN: op[1]=1 selects multu/divu; otherwise all ops are signed.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;

  logic             uns_c;
  logic             sa_c;
  logic             sb_c;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [2*WIDTH-1:0] fix_p;
  logic [WIDTH-1:0] fix_r;
  logic [WIDTH:0]   mult_sum;
  logic [WIDTH+1:0] div_trial;

`ifdef MULTDIV_UNSIGNED_EN
  assign uns_c = op[OP_UNSIGNED_BIT];
`else
  logic unused_op_hi;
  assign uns_c        = 1'b0;
  assign unused_op_hi = op[OP_UNSIGNED_BIT];
`endif

  // Sign flags are forced low for unsigned ops, which also disables the fixup negation.
  assign sa_c = a_in[WIDTH-1] & ~uns_c;
  assign sb_c = b_in[WIDTH-1] & ~uns_c;

  md_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(sa_c), .a(a_in), .y(mag_a));
  md_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(sb_c), .a(b_in), .y(mag_b));

  // Full-width negate gives the signed product; its low half is also the negated quotient.
  md_negate #(.WIDTH(2*WIDTH)) u_fix_p (
    .neg(sign_a ^ sign_b), .a({r[WIDTH-1:0], q}), .y(fix_p)
  );
  md_negate #(.WIDTH(WIDTH)) u_fix_r (.neg(sign_a), .a(r[WIDTH-1:0]), .y(fix_r));

  assign mult_sum  = {1'b0, r[WIDTH-1:0]} + (q[0] ? {1'b0, m} : '0);
  assign div_trial = {r, q[WIDTH-1]} - {2'b00, m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      r        <= '0;
      q        <= '0;
      m        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (start) begin
            is_div <= (op[0] == 1'(OP_DIV));
            sign_a <= sa_c;
            sign_b <= sb_c;
            r      <= '0;
            q      <= mag_a;
            m      <= mag_b;
            cnt    <= '0;
            if (op[0] == 1'(OP_DIV) && b_in == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            if (!div_trial[WIDTH+1]) begin
              r <= div_trial[WIDTH:0];
              q <= {q[WIDTH-2:0], 1'b1};
            end else begin
              r <= {r[WIDTH-1:0], q[WIDTH-1]};
              q <= {q[WIDTH-2:0], 1'b0};
            end
          end else begin
            r <= {1'b0, mult_sum[WIDTH:1]};
            q <= {mult_sum[0], q[WIDTH-1:1]};
          end
          if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi_out <= fix_r;
            lo_out <= fix_p[WIDTH-1:0];
          end else begin
            hi_out <= fix_p[2*WIDTH-1:WIDTH];
            lo_out <= fix_p[WIDTH-1:0];
          end
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit: signed mult/div, divide-by-zero, reset abort.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    logic [31:0]  lat;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Issues one operation and returns in its done cycle; eacc = edges until acceptance.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic edz, input int elat, input int eacc, input bit poke);
    exp_t e;
    int   n;
    sb.push_back('{hi: eh, lo: el, dz: edz, lat: 32'(elat)});
    op = o; a_in = a; b_in = b; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(busy || done) && n < 5);
    check({tag, ":accept"}, 64'(n), 64'(eacc));
    start = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
    check({tag, ":busy"}, 64'(busy), 64'(!edz));
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
      if (poke && n == 5) begin
        start = 1'b1; op = 2'(OP_MULT); a_in = 32'h1234_5678; b_in = 32'h0000_0003;
      end
      if (poke && n == 6) start = 1'b0;
    end
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      check({tag, ":latency"}, 64'(n), 64'(e.lat));
      check({tag, ":hi"}, 64'(hi_out), 64'(e.hi));
      check({tag, ":lo"}, 64'(lo_out), 64'(e.lo));
      check({tag, ":div_zero"}, 64'(div_zero), 64'(e.dz));
      check({tag, ":busy_done"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:done", 64'(done), 64'(0));
    check("rst:div_zero", 64'(div_zero), 64'(0));
    check("rst:hi", 64'(hi_out), 64'(0));
    check("rst:lo", 64'(lo_out), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_op("mul_7_m3",    2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1, 1'b0);
    do_op("mul_min_min", 2'b00, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33, 2, 1'b0);
    do_op("div_100_7",   2'b01, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 33, 2, 1'b1);
    do_op("div_m7_2",    2'b01, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 2, 1'b0);
    do_op("div_min_m1",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 2, 1'b0);
    do_op("div_100_7b",  2'b01, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 33, 2, 1'b0);
    do_op("div_5_0",     2'b01, 32'd5,          32'd0,         32'd2,         32'd14,        1'b1, 0,  2, 1'b0);

    @(posedge clk); #1;
    check("dz:done_clear", 64'(done), 64'(0));
    check("dz:flag_clear", 64'(div_zero), 64'(0));

    // Abort a multiply ten cycles in; no stale done may follow.
    op = 2'b00; a_in = 32'd9; b_in = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort:busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    check("abort:busy", 64'(busy), 64'(0));
    check("abort:hi", 64'(hi_out), 64'(0));
    check("abort:lo", 64'(lo_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check("abort:no_done", 64'(n), 64'(0));

    do_op("mul_after_rst", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1, 1'b0);
`ifdef MULTDIV_UNSIGNED_EN
    do_op("mulu", 2'b10, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, 33, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multicycle multiply/divide unit with HI/LO result registers. It fills the MULT/DIV/HI/LO slot of the multicycle CPU datapath. The unit is a parametrised successor to a fixed 32-bit HI/LO block. It takes operands from Reg_A/Reg_B, runs a start/busy/done handshake with the controladora, and raises a divide-by-zero flag for the exception path.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  2  bit0: 0=mult, 1=div. bit1: 1=unsigned, honoured only with MULTDIV_UNSIGNED_EN.
- a_in  in  WIDTH  multiplicand / dividend (from Reg_A).
- b_in  in  WIDTH  multiplier / divisor (from Reg_B).
- busy  out  1  high from the accept edge until the done cycle (exclusive).
- done  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- div_zero  out  1  one-cycle pulse coincident with done, for a div with b_in=0.
- hi_out  out  WIDTH  HI register: product upper half / remainder.
- lo_out  out  WIDTH  LO register: product lower half / quotient.

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE with start=1:
  - The unit latches op, the sign flags, and the operand magnitudes. Magnitude is the two's-complement absolute value when the op is signed.
  - The iteration counter is cleared.
  - Next state is RUN. If op is div and b_in=0, next state is DONE instead, with div_zero pending.
- RUN, mult: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
- RUN, div: restoring division, one quotient bit per cycle, WIDTH cycles. The remainder register is WIDTH+1 bits wide.
- FIXUP, signed mult: the product is negated when the operand signs differ.
- FIXUP, signed div: the quotient is negated when the signs differ. The remainder takes the sign of the dividend.
- FIXUP, write: HI/LO are written at the edge that leaves FIXUP, and the next state is DONE.
- DONE: done=1 for one cycle, with div_zero=1 if pending. The next state is IDLE.
- Divide by zero: hi_out and lo_out are left unchanged.
- Signed MIN / −1 does not trap. The result is lo=MIN, hi=0.
- start while busy=1 is ignored and is not queued.
- HI/LO hold their value between operations. Only a completed non-zero-divisor operation writes them.
- a_in, b_in and op are don't-care after the accept edge.

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
- Reset mid-operation aborts the operation. No partial result is ever visible.
- Normal latency: the accept edge is E0. RUN occupies E1..E_WIDTH. FIXUP ends at E_WIDTH+1.
  - done is high in the cycle after E_WIDTH+1.
  - For WIDTH=32 that is 33 cycles after the accept edge.
- Divide-by-zero latency: done and div_zero are high in the cycle after E0.
- busy rises at E0 and falls at the edge that enters DONE. busy is low during the done cycle.
- Back-to-back: a start asserted during the done cycle is not accepted, because the state is still DONE. The earliest acceptance is at the edge ending the IDLE cycle that follows.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.

## Configuration
- MULTDIV_UNSIGNED_EN defined: op[1]=1 selects multu/divu.
  - No magnitude conversion and no FIXUP sign correction.
  - FIXUP is still occupied, so latency is identical.
- MULTDIV_UNSIGNED_EN undefined: op[1] is ignored and all operations are signed. The unsigned-select logic is not compiled.

## Structure
- Package mult_div_pkg holds:
  - the state enum;
  - the op-field constants: OP_MULT=0, OP_DIV=1, OP_UNSIGNED_BIT=1;
  - the counter width function clog2(WIDTH+1).
- One sub-module, md_negate: parametrised combinational conditional two's-complement negate. It is used for the operand magnitudes and for the FIXUP corrections.

## Test plan
- Signed mult: a=7, b=0xFFFFFFFD (−3) → at cycle 33, done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
- Signed mult: a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- Divs:
  - 100/7 → lo=14, hi=2.
  - 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Div 5/0 after a prior result hi=2, lo=14 → done and div_zero high one cycle after accept, hi=2, lo=14 unchanged. A start during busy is ignored.
- Reset mid-operation: assert rst 10 cycles into a mult → immediately busy=0, hi=lo=0. No done appears in the next 40 cycles.
- With MULTDIV_UNSIGNED_EN, op=2'b10, a=0xFFFFFFFF, b=2 → hi=1, lo=0xFFFFFFFE. Repeat with WIDTH=16: latency is 17 cycles.
